mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port memory interface between the instruction-fetch stage and the load/store unit. Every cycle it grants at most one requester and drives the memory port. It tracks in-order outstanding reads so each `mem_rvld` beat reaches the requester that issued it. It sits between the fetch/LSU memory ports and the unified memory.

## Interface
- `MAX_OUTST`, default 2: maximum reads in flight (owner FIFO depth, ≥1).
- `STARVE_LIMIT`, default 4: consecutive LSU-over-IF wins before IF is forced (≥1; used only with the guard compiled in).
- `CLK` input 1: the single clock; all state updates on the rising edge.
- `RSTN` input 1: reset is synchronous and active-low.
- `if_req` input 1: fetch read request, held until granted.
- `if_addr` input 32: fetch address.
- `if_gnt` output 1: fetch request accepted this cycle.
- `if_rvld` output 1: fetch read data valid.
- `if_kill` input 1: squash all fetch reads in flight (branch flush).
- `lsu_req` input 1: LSU request, held until granted.
- `lsu_addr` input 32: LSU address.
- `lsu_wdata` input 32: LSU write data.
- `lsu_wen` input 4: byte write enables; 0 means a read.
- `lsu_gnt` output 1: LSU request accepted this cycle.
- `lsu_rvld` output 1: LSU read data valid.
- `rdata` output 32: `mem_rdata` passthrough, shared by both requesters.
- `mem_en` output 1: memory access strobe.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_wen` output 4: memory byte write enables.
- `mem_rdata` input 32: memory read data.
- `mem_rvld` input 1: read response, in issue order, latency ≥1 cycle.
- `err_orphan` output 1: sticky flag; `mem_rvld` arrived with no read outstanding.

## Operation
- **Grant is combinational.** Grants are one-hot or both 0.
- **Read eligibility.** A read is eligible only when the owner FIFO is not full, or is full with a pop in the same cycle.
- **Write eligibility.** LSU writes need no FIFO slot and are always eligible.
- **Priority.** The LSU has priority when both requesters are eligible, except when the starvation guard forces IF (see Configuration).
- **Memory port drive.** Memory outputs mux from the granted requester. `mem_en` = `if_gnt | lsu_gnt`.
- **Idle port.** When nothing is granted, `mem_addr`, `mem_wdata` and `mem_wen` are 0.
- **Issued fetch.** Pushes owner IF with kill bit 0. `mem_wen` = 0.
- **Issued LSU read.** Pushes owner LSU.
- **Issued LSU write.** Pushes nothing.
- **Response.** `mem_rvld` pops the FIFO head.
  - `if_rvld` = `mem_rvld` & head owner IF & head kill bit 0.
  - `lsu_rvld` = `mem_rvld` & head owner LSU.
  - `rdata` = `mem_rdata` always.
- **Kill.** `if_kill` sets the kill bit on every IF entry in the FIFO, including an entry being popped that cycle, whose `if_rvld` is suppressed.
  - An IF push in the same cycle as `if_kill` is not killed; it is the redirected fetch.
- **Simultaneous push and pop.** Legal, including when full. The occupancy count is unchanged.
- **Orphan response.** `mem_rvld` with the FIFO empty is dropped, sets `err_orphan`, and produces no `rvld`.

## Timing
- **Grant latency.** 0 cycles, request to grant to `mem_en`, all in the same cycle.
- **Response latency.** 0 cycles, `mem_rvld` to `if_rvld`/`lsu_rvld`.
- **Registered state.** Owner FIFO (pointers, count, owner and kill bits), starvation counter, `err_orphan`.
- **Reset values.** On a `RSTN` low sample:
  - FIFO empty, all kill bits 0.
  - Starvation counter 0.
  - `err_orphan` 0.
  - With requests low, all outputs 0.
- **Reset mid-operation.** Every in-flight read is forgotten. Later responses count as orphans.
- **Pointer wrap.** Read and write pointers wrap modulo `MAX_OUTST`. The count uses ceil(log2(`MAX_OUTST`+1)) bits.

## Configuration
- **`ARB_STARVE_GUARD_EN` defined.**
  - The counter increments each cycle in which IF requested, was eligible, and the LSU was granted.
  - Once the counter equals `STARVE_LIMIT`, the next cycle in which IF is eligible grants IF over the LSU.
  - The counter clears when IF is granted or `if_req` is low.
  - The counter saturates at `STARVE_LIMIT`.
- **`ARB_STARVE_GUARD_EN` not defined.** Fixed LSU priority. No counter exists. `STARVE_LIMIT` is ignored.

## Structure
- **Shared package** (`mem_arb_pkg`):
  - Owner encodings `OWNER_IF` = 1'b0, `OWNER_LSU` = 1'b1.
  - FIFO entry typedef {kill, owner}.
  - Memory data width 32 and strobe width 4.
- **Sub-module.** `owner_fifo` is the natural split: a parameterised-depth in-order FIFO with push/pop and a broadcast-kill-by-owner port.
- **Top level.** Holds the arbitration, starvation counter, port mux and response routing.

## Test plan
- **Contention.** `if_req` and an LSU read both held, memory latency 1 → LSU granted in cycle 0, IF in cycle 1. Responses route to `lsu_rvld` then `if_rvld` with `rdata` 0xA5A5_0000 then 0x0000_1234.
- **Starvation guard** (`ARB_STARVE_GUARD_EN`, `STARVE_LIMIT`=4, write-only LSU stream, `if_req` held) → LSU granted in cycles 0–3, IF in cycle 4, LSU resumes in cycle 5. Without the macro, IF is never granted while `lsu_req` is high.
- **FIFO full** (`MAX_OUTST`=2, response latency 3, LSU reads back-to-back) → two grants, `lsu_gnt` 0 until the first `mem_rvld`, then a grant in the pop cycle. LSU writes are still granted while full.
- **Kill.** Two IF reads in flight, then `if_kill` plus a new IF grant in the same cycle → the two old responses give `if_rvld` 0, the third gives `if_rvld` 1.
- **Orphan.** `mem_rvld` with no reads in flight → `err_orphan` rises next cycle and stays high until `RSTN` low. No `rvld` pulses.
- **Reset mid-flight.** One read outstanding, `RSTN` low for 1 cycle → the FIFO count reads 0, and the late response sets `err_orphan`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and widths for the fetch/LSU memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: owner encoding, owner-FIFO entry type, data/strobe widths,
// width helpers for pointers and occupancy counters.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   kill;
    owner_e owner;
  } fifo_ent_t;

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer indexes 0..depth-1; a depth of 1 still needs one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// Purpose: in-order FIFO recording who issued each outstanding read, with broadcast kill by owner.
// Latency: push visible at head next cycle; head and kill merge are combinational.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk/rstn (sync active-low), push_vld/push_owner, pop_vld,
// kill_vld/kill_owner (mark every matching entry killed), head_owner/head_kill,
// empty/full status.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_vld,
  input  logic push_owner,
  input  logic pop_vld,
  input  logic kill_vld,
  input  logic kill_owner,
  output logic head_owner,
  output logic head_kill,
  output logic empty,
  output logic full
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  fifo_ent_t      ent_q [DEPTH];
  fifo_ent_t      ent_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign do_pop  = pop_vld & ~empty;
  // A full FIFO can still accept a push when the head leaves this cycle.
  assign do_push = push_vld & (~full | do_pop);

  // The head seen by the response path already includes this cycle's kill,
  // so a response popping a just-killed fetch is suppressed immediately.
  assign head_owner = ent_q[rd_ptr_q].owner;
  assign head_kill  = ent_q[rd_ptr_q].kill |
                      (kill_vld & (ent_q[rd_ptr_q].owner == owner_e'(kill_owner)));

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (kill_vld) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_q[i].owner == owner_e'(kill_owner)) begin
          ent_d[i].kill = 1'b1;
        end
      end
    end

    // Push is applied after the kill sweep: a same-cycle push survives the kill.
    if (do_push) begin
      ent_d[wr_ptr_q].kill  = 1'b0;
      ent_d[wr_ptr_q].owner = owner_e'(push_owner);
      wr_ptr_d              = inc_ptr(wr_ptr_q);
    end

    if (do_pop) begin
      rd_ptr_d = inc_ptr(rd_ptr_q);
    end

    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: share one single-port memory between instruction fetch and the LSU, routing read data back in order.
// Latency: 0 cycles request->grant->mem_en, 0 cycles mem_rvld->if_rvld/lsu_rvld.
// Backpressure: reads stall when MAX_OUTST reads are in flight (unless one retires this cycle); writes never stall.
// Ports: CLK/RSTN (sync active-low); fetch side if_req/if_addr/if_gnt/if_rvld/if_kill;
// LSU side lsu_req/lsu_addr/lsu_wdata/lsu_wen/lsu_gnt/lsu_rvld; shared rdata;
// memory side mem_en/mem_addr/mem_wdata/mem_wen/mem_rdata/mem_rvld; sticky err_orphan.
// Build option: define ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_LIMIT consecutive LSU wins over an eligible fetch; otherwise fixed LSU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTST    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvld,
  input  logic              if_kill,
  input  logic              lsu_req,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_wen,
  output logic              lsu_gnt,
  output logic              lsu_rvld,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvld,
  output logic              err_orphan
);

  if (MAX_OUTST < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_OUTST and STARVE_LIMIT must be >= 1");
  end

  logic fifo_empty, fifo_full;
  logic head_owner, head_kill;
  logic pop_vld, push_vld, push_owner;
  logic rd_slot_ok, lsu_is_wr;
  logic if_elig, lsu_elig, force_if;
  logic err_orphan_q, err_orphan_d;

  // A response only retires something if a read is actually outstanding.
  assign pop_vld    = mem_rvld & ~fifo_empty;
  assign rd_slot_ok = ~fifo_full | pop_vld;
  assign lsu_is_wr  = |lsu_wen;

  assign if_elig  = if_req & rd_slot_ok;
  assign lsu_elig = lsu_req & (lsu_is_wr | rd_slot_ok);

  assign lsu_gnt = lsu_elig & ~force_if;
  assign if_gnt  = if_elig & ~lsu_gnt;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = cnt_w(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  assign force_if = (starve_q == SW'(STARVE_LIMIT)) & if_elig;

  // Counts consecutive cycles where an eligible fetch lost to the LSU.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (if_elig && lsu_gnt && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Memory port mux; idle port drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = '0;
    if (lsu_gnt) begin
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
      mem_wen   = lsu_wen;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign mem_en = if_gnt | lsu_gnt;

  // Writes retire without a response, so only reads take an owner slot.
  assign push_vld   = if_gnt | (lsu_gnt & ~lsu_is_wr);
  assign push_owner = lsu_gnt ? OWNER_LSU : OWNER_IF;

  owner_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk        (CLK),
    .rstn       (RSTN),
    .push_vld   (push_vld),
    .push_owner (push_owner),
    .pop_vld    (pop_vld),
    .kill_vld   (if_kill),
    .kill_owner (OWNER_IF),
    .head_owner (head_owner),
    .head_kill  (head_kill),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign if_rvld  = pop_vld & (head_owner == OWNER_IF) & ~head_kill;
  assign lsu_rvld = pop_vld & (head_owner == OWNER_LSU);
  assign rdata    = mem_rdata;

  always_comb begin
    err_orphan_d = err_orphan_q | (mem_rvld & fifo_empty);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      err_orphan_q <= 1'b0;
    end else begin
      err_orphan_q <= err_orphan_d;
    end
  end

  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAXO  = 2;
  localparam int LIMIT = 4;

  logic        CLK, RSTN;
  logic        if_req, if_gnt, if_rvld, if_kill;
  logic [31:0] if_addr;
  logic        lsu_req, lsu_gnt, lsu_rvld;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wen;
  logic [31:0] rdata;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;
  logic        mem_rvld, err_orphan;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MAX_OUTST(MAXO), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvld(if_rvld), .if_kill(if_kill),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen),
    .lsu_gnt(lsu_gnt), .lsu_rvld(lsu_rvld), .rdata(rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_rvld(mem_rvld), .err_orphan(err_orphan)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; if_kill = 0;
    lsu_req = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0;
    mem_rvld = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RSTN = 0;
    tick(); tick();
    RSTN = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RSTN = 0;
    tick();
    #1;
    checks++; if (if_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt if=%0b lsu=%0b exp=0,0", if_gnt, lsu_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wen !== 4'h0) begin errors++; $display("FAIL reset_port en=%0b addr=%h wd=%h wen=%h exp=0", mem_en, mem_addr, mem_wdata, mem_wen); end
    checks++; if (if_rvld !== 1'b0 || lsu_rvld !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_rvld if=%0b lsu=%0b rdata=%h exp=0", if_rvld, lsu_rvld, rdata); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err_orphan); end
    RSTN = 1;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    if_req = 1; if_addr = 32'h100; lsu_req = 1; lsu_addr = 32'h200; lsu_wen = 0;
    #1;
    checks++; if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL cont_c0_gnt lsu=%0b if=%0b exp=1,0", lsu_gnt, if_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || mem_wen !== 4'h0) begin errors++; $display("FAIL cont_c0_port en=%0b addr=%h wen=%h exp=1,200,0", mem_en, mem_addr, mem_wen); end
    tick();
    lsu_req = 0; mem_rvld = 1; mem_rdata = 32'hA5A5_0000;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL cont_c1_if_gnt gnt=%0b addr=%h exp=1,100", if_gnt, mem_addr); end
    checks++; if (lsu_rvld !== 1'b1 || if_rvld !== 1'b0 || rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL cont_c1_rsp lsu=%0b if=%0b rdata=%h exp=1,0,a5a50000", lsu_rvld, if_rvld, rdata); end
    tick();
    if_req = 0; mem_rdata = 32'h0000_1234;
    #1;
    checks++; if (if_rvld !== 1'b1 || lsu_rvld !== 1'b0 || rdata !== 32'h0000_1234) begin errors++; $display("FAIL cont_c2_rsp if=%0b lsu=%0b rdata=%h exp=1,0,1234", if_rvld, lsu_rvld, rdata); end
    tick();
    mem_rvld = 0;
    #1;
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL cont_err got=%0b exp=0", err_orphan); end
  endtask

  task automatic test_starvation();
    bit exp_if;
    do_reset();
    if_req = 1; if_addr = 32'h40; lsu_req = 1; lsu_addr = 32'h80; lsu_wdata = 32'hDEAD; lsu_wen = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = (i == LIMIT);
`else
      exp_if = 1'b0;
`endif
      checks++; if (if_gnt !== exp_if || lsu_gnt !== !exp_if) begin errors++; $display("FAIL starve_c%0d if=%0b lsu=%0b exp_if=%0b", i, if_gnt, lsu_gnt, exp_if); end
      tick();
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    lsu_req = 1; lsu_addr = 32'h300; lsu_wen = 0;
    #1;
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL full_c0_gnt got=%0b exp=1", lsu_gnt); end
    tick(); #1;
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL full_c1_gnt got=%0b exp=1", lsu_gnt); end
    tick(); #1;
    checks++; if (lsu_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL full_c2_stall gnt=%0b en=%0b exp=0,0", lsu_gnt, mem_en); end
    lsu_wen = 4'h3; lsu_wdata = 32'h5555_AAAA;
    #1;
    checks++; if (lsu_gnt !== 1'b1 || mem_wen !== 4'h3 || mem_wdata !== 32'h5555_AAAA) begin errors++; $display("FAIL full_c2_write gnt=%0b wen=%h wd=%h exp=1,3,5555aaaa", lsu_gnt, mem_wen, mem_wdata); end
    tick();
    lsu_wen = 0; mem_rvld = 1; mem_rdata = 32'h11;
    #1;
    checks++; if (lsu_gnt !== 1'b1 || lsu_rvld !== 1'b1) begin errors++; $display("FAIL full_c3_pop_gnt gnt=%0b rvld=%0b exp=1,1", lsu_gnt, lsu_rvld); end
    tick();
    lsu_req = 0;
    #1;
    checks++; if (lsu_rvld !== 1'b1) begin errors++; $display("FAIL full_c4_rvld got=%0b exp=1", lsu_rvld); end
    tick(); #1;
    checks++; if (lsu_rvld !== 1'b1) begin errors++; $display("FAIL full_c5_rvld got=%0b exp=1", lsu_rvld); end
    tick();
    mem_rvld = 0;
    #1;
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL full_err got=%0b exp=0", err_orphan); end
  endtask

  task automatic test_kill();
    do_reset();
    if_req = 1; if_addr = 32'hA0;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL kill_c0_gnt got=%0b exp=1", if_gnt); end
    tick(); if_addr = 32'hA4;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL kill_c1_gnt got=%0b exp=1", if_gnt); end
    tick();
    if_addr = 32'hC0; if_kill = 1; mem_rvld = 1;
    #1;
    checks++; if (if_gnt !== 1'b1 || if_rvld !== 1'b0) begin errors++; $display("FAIL kill_c2 gnt=%0b rvld=%0b exp=1,0", if_gnt, if_rvld); end
    tick();
    if_req = 0; if_kill = 0;
    #1;
    checks++; if (if_rvld !== 1'b0) begin errors++; $display("FAIL kill_c3_old_rvld got=%0b exp=0", if_rvld); end
    tick(); #1;
    checks++; if (if_rvld !== 1'b1) begin errors++; $display("FAIL kill_c4_new_rvld got=%0b exp=1", if_rvld); end
    tick();
    mem_rvld = 0;
  endtask

  task automatic test_orphan();
    do_reset();
    mem_rvld = 1; mem_rdata = 32'hBAD;
    #1;
    checks++; if (if_rvld !== 1'b0 || lsu_rvld !== 1'b0 || err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_c0 if=%0b lsu=%0b err=%0b exp=0,0,0", if_rvld, lsu_rvld, err_orphan); end
    tick();
    mem_rvld = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky_%0d got=%0b exp=1", i, err_orphan); end
      tick();
    end
    RSTN = 0; tick(); RSTN = 1;
    #1;
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_cleared got=%0b exp=0", err_orphan); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lsu_req = 1; lsu_addr = 32'h500; lsu_wen = 0;
    #1;
    checks++; if (lsu_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got=%0b exp=1", lsu_gnt); end
    tick();
    lsu_req = 0; RSTN = 0;
    tick();
    RSTN = 1;
    #1;
    checks++; if (dut.u_fifo.count_q !== '0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", dut.u_fifo.count_q); end
    mem_rvld = 1;
    #1;
    checks++; if (lsu_rvld !== 1'b0 || if_rvld !== 1'b0) begin errors++; $display("FAIL midrst_rvld lsu=%0b if=%0b exp=0,0", lsu_rvld, if_rvld); end
    tick();
    mem_rvld = 0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL midrst_err got=%0b exp=1", err_orphan); end
  endtask

  // Reference model: a list of outstanding reads (owner, killed) plus a
  // memory that answers each read in order after a random delay.
  task automatic test_random();
    bit q_own[$];
    bit q_kill[$];
    int due_q[$];
    int cyc = 0;
    int starve = 0;
    bit exp_err = 0;
    bit pop, room, e_if_ok, e_if, e_lsu, e_if_rvld, e_lsu_rvld, is_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wen;
    int d;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (!lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      if_kill   = ($urandom_range(0, 9) == 0);
      mem_rvld  = (due_q.size() > 0 && due_q[0] == cyc);
      mem_rdata = $urandom;
      #1;
      is_wr = (lsu_wen != 4'h0);
      pop   = mem_rvld && (q_own.size() > 0);
      room  = (q_own.size() < MAXO) || pop;
      e_lsu   = lsu_req && (is_wr || room);
      e_if_ok = if_req && room;
`ifdef ARB_STARVE_GUARD_EN
      if (starve >= LIMIT && e_if_ok) e_lsu = 0;
`endif
      e_if = e_if_ok && !e_lsu;
      e_if_rvld = 0; e_lsu_rvld = 0;
      if (pop) begin
        e_if_rvld  = (q_own[0] == 0) && !q_kill[0] && !if_kill;
        e_lsu_rvld = (q_own[0] == 1);
      end
      e_addr  = e_lsu ? lsu_addr : (e_if ? if_addr : 32'h0);
      e_wdata = e_lsu ? lsu_wdata : 32'h0;
      e_wen   = e_lsu ? lsu_wen : 4'h0;
      checks++; if (if_gnt !== e_if || lsu_gnt !== e_lsu) begin errors++; $display("FAIL rnd_gnt cyc=%0d if=%0b lsu=%0b exp=%0b,%0b", cyc, if_gnt, lsu_gnt, e_if, e_lsu); end
      checks++; if (mem_en !== (e_if | e_lsu) || mem_addr !== e_addr || mem_wdata !== e_wdata || mem_wen !== e_wen) begin errors++; $display("FAIL rnd_port cyc=%0d en=%0b addr=%h wd=%h wen=%h exp addr=%h wd=%h wen=%h", cyc, mem_en, mem_addr, mem_wdata, mem_wen, e_addr, e_wdata, e_wen); end
      checks++; if (if_rvld !== e_if_rvld || lsu_rvld !== e_lsu_rvld || rdata !== mem_rdata) begin errors++; $display("FAIL rnd_rsp cyc=%0d if=%0b lsu=%0b exp=%0b,%0b rdata=%h", cyc, if_rvld, lsu_rvld, e_if_rvld, e_lsu_rvld, rdata); end
      checks++; if (err_orphan !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err_orphan, exp_err); end
      // advance the model to the next cycle
      if (!if_req || e_if) starve = 0;
      else if (e_if_ok && e_lsu && starve < LIMIT) starve++;
      if (mem_rvld && q_own.size() == 0) exp_err = 1;
      if (mem_rvld) void'(due_q.pop_front());
      if (pop) begin void'(q_own.pop_front()); void'(q_kill.pop_front()); end
      if (if_kill) foreach (q_kill[i]) if (q_own[i] == 0) q_kill[i] = 1;
      if (e_if || (e_lsu && !is_wr)) begin
        q_own.push_back(e_lsu ? 1'b1 : 1'b0);
        q_kill.push_back(1'b0);
        d = cyc + $urandom_range(1, 4);
        if (due_q.size() > 0 && d <= due_q[$]) d = due_q[$] + 1;
        due_q.push_back(d);
      end
      tick();
      cyc++;
      if (e_if) if_req = 0;
      if (e_lsu) lsu_req = 0;
    end
    clear_inputs();
  endtask

  initial begin
    RSTN = 0;
    clear_inputs();
    test_reset();
    test_contention();
    test_starvation();
    test_fifo_full();
    test_kill();
    test_orphan();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
